// File: rtl/column_frame_strobe_gen_if.sv
// ============================================================================
// Module      : column_frame_strobe_gen_if
// Description : Frame-write request handshake bundle for the column strobe
//               generator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface column_frame_strobe_gen_if #(
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5
);
  logic                        req_valid;
  logic                        req_ready;
  logic [FrameSelectWidth-1:0] req_frame_addr;
  logic [ColSelectWidth-1:0]   req_col_addr;

  // Requester side
  modport master (
    output req_valid,
    output req_frame_addr,
    output req_col_addr,
    input  req_ready
  );

  // Strobe generator side
  modport slave (
    input  req_valid,
    input  req_frame_addr,
    input  req_col_addr,
    output req_ready
  );
endinterface

`default_nettype wire

// File: rtl/column_frame_strobe_gen.sv
// ============================================================================
// Module      : column_frame_strobe_gen
// Description : Turns accepted frame-write requests into a registered one-hot
//               FrameStrobe pulse of programmable width, followed by a
//               programmable idle gap, for a single fabric column.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module column_frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5,
  parameter int ColIndex         = 0,
  parameter int StrobeWidth      = 2,
  parameter int GapCycles        = 1
) (
  input  wire logic                       UserCLK,
  input  wire logic                       reset,
  column_frame_strobe_gen_if.slave        req,
  output logic [MaxFramesPerCol-1:0]      FrameStrobe,
  output logic                            busy,
  output logic                            addr_err,
  output logic [15:0]                     strobe_count
);

  // A zero strobe width still produces a single-cycle strobe.
  localparam int SwEff  = (StrobeWidth < 1) ? 1 : StrobeWidth;
  localparam int CntMax = (SwEff > GapCycles) ? SwEff : GapCycles;
  // The counter only ever holds (phase length - 1).
  localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [MaxFramesPerCol-1:0] frame_strobe_q, frame_strobe_d;
  logic                       addr_err_q, addr_err_d;
  logic [15:0]                strobe_count_q, strobe_count_d;

  logic                       col_hit;
  logic                       frame_in_range;
  logic [MaxFramesPerCol-1:0] frame_onehot;

  // Decode the presented address; only meaningful in the accepting cycle.
  always_comb begin
    col_hit        = (req.req_col_addr == ColSelectWidth'(ColIndex));
    frame_in_range = (32'(req.req_frame_addr) < MaxFramesPerCol);
    frame_onehot   = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      frame_onehot[i] = (32'(req.req_frame_addr) == i);
    end
  end

  // Next-state logic: one down-counter times both the STROBE and GAP phases.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_strobe_d = frame_strobe_q;
    addr_err_d     = 1'b0;
    strobe_count_d = strobe_count_q;

    case (state_q)
      IDLE: begin
        frame_strobe_d = '0;
        if (req.req_valid && col_hit) begin
          if (frame_in_range) begin
            // Address is captured here as the one-hot pattern itself.
            state_d        = STROBE;
            cnt_d          = CntW'(SwEff - 1);
            frame_strobe_d = frame_onehot;
            if (strobe_count_q != 16'hFFFF) begin
              strobe_count_d = strobe_count_q + 16'd1;
            end
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          frame_strobe_d = '0;
          if (GapCycles == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = GAP;
            cnt_d   = CntW'(GapCycles - 1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      GAP: begin
        frame_strobe_d = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: begin
        state_d        = IDLE;
        cnt_d          = '0;
        frame_strobe_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears the strobe without a clock edge.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_strobe_q <= '0;
      addr_err_q     <= 1'b0;
      strobe_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_strobe_q <= frame_strobe_d;
      addr_err_q     <= addr_err_d;
      strobe_count_q <= strobe_count_d;
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign FrameStrobe   = frame_strobe_q;
  assign addr_err      = addr_err_q;
  assign strobe_count  = strobe_count_q;

endmodule

`default_nettype wire
